// File: rtl/keccak_pi_sequencer_pkg.sv
// Shared constants and state encoding for the lane-permutation sequencer
// and the lane-map/converter chain fed by its lane counter.
package keccak_pi_sequencer_pkg;

  localparam int LANES          = 25;
  localparam int IDX_W          = 5;
  localparam int RD_TIMEOUT_DEF = 255;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_INIT   = 3'd1;
  localparam state_t S_READ   = 3'd2;
  localparam state_t S_LOAD   = 3'd3;
  localparam state_t S_WSETUP = 3'd4;
  localparam state_t S_WRITE  = 3'd5;
  localparam state_t S_DONE   = 3'd6;

  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  function automatic logic is_last_lane(input logic [IDX_W-1:0] idx);
    return idx == LAST_LANE;
  endfunction

endpackage

// File: rtl/keccak_pi_sequencer_if.sv
// Handshake bundle between the sequencer and the reader, memory handler,
// lane counter and file writer.
interface keccak_pi_sequencer_if;
  import keccak_pi_sequencer_pkg::*;

  logic             start;
  logic             abort;
  logic             rd_valid;
  logic             wr_ready;
  logic             read_data;
  logic             cnt_init;
  logic             cnt_en;
  logic             ldn;
  logic             write_to_file;
  logic [IDX_W-1:0] lane_idx;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, rd_valid, wr_ready,
    input  read_data, cnt_init, cnt_en, ldn, write_to_file, lane_idx, busy, done, err
  );

  modport slave (
    input  start, abort, rd_valid, wr_ready,
    output read_data, cnt_init, cnt_en, ldn, write_to_file, lane_idx, busy, done, err
  );

endinterface

// File: rtl/keccak_pi_sequencer_rd_timeout_timer.sv
// Counts consecutive cycles spent waiting for a lane from the reader;
// expired fires on the wait cycle that would bring the count to LIMIT.
module keccak_pi_sequencer_rd_timeout_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] TC = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = inc && (cnt_q == TC);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keccak_pi_sequencer.sv
// Sequences one lane-permutation pass: read and load 25 lanes at their
// permuted addresses, then stream all 25 permuted lanes to the file writer.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | clear lane counter
// READ   | request lane from reader, wait for rd_valid (timed)
// LOAD   | memory handler stores lane at converted address
// WSETUP | counter/mapping settle before streaming out
// WRITE  | present lane to file writer, advance on wr_ready
// DONE   | one-cycle completion pulse
module keccak_pi_sequencer
  import keccak_pi_sequencer_pkg::*;
#(
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input logic                  clk,
  input logic                  rst,
  keccak_pi_sequencer_if.slave sq
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] lane_q;
  logic             err_q;
  logic             wait_rd;
  logic             expired;
  logic             lane_init;
  logic             lane_step;
  logic             err_set;
  logic             err_clr;

  assign wait_rd = (state_q == S_READ) && !sq.rd_valid;

  keccak_pi_sequencer_rd_timeout_timer #(
    .LIMIT (RD_TIMEOUT)
  ) u_rd_timeout_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!wait_rd),
    .inc     (wait_rd),
    .expired (expired)
  );

  // Counter strobes are decoded alongside the lane_idx update so the
  // external lane counter and lane_idx never disagree.
  always_comb begin
    state_d   = state_q;
    lane_init = 1'b0;
    lane_step = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    if (sq.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sq.start) begin
            state_d = S_INIT;
            err_clr = 1'b1;
          end
        end
        S_INIT: begin
          lane_init = 1'b1;
          state_d   = S_READ;
        end
        S_READ: begin
          if (sq.rd_valid) begin
            state_d = S_LOAD;
          end else if (expired) begin
            state_d = S_IDLE;
            err_set = 1'b1;
          end
        end
        S_LOAD: begin
          if (is_last_lane(lane_q)) begin
            lane_init = 1'b1;
            state_d   = S_WSETUP;
          end else begin
            lane_step = 1'b1;
            state_d   = S_READ;
          end
        end
        S_WSETUP: state_d = S_WRITE;
        S_WRITE: begin
          if (sq.wr_ready) begin
            if (is_last_lane(lane_q)) begin
              state_d = S_DONE;
            end else begin
              lane_step = 1'b1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (lane_init) begin
        lane_q <= '0;
      end else if (lane_step) begin
        lane_q <= lane_q + IDX_W'(1);
      end
      if (err_clr) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign sq.read_data     = (state_q == S_READ);
  assign sq.ldn           = (state_q == S_LOAD);
  assign sq.write_to_file = (state_q == S_WRITE);
  assign sq.done          = (state_q == S_DONE);
  assign sq.busy          = (state_q != S_IDLE);
  assign sq.cnt_init      = lane_init;
  assign sq.cnt_en        = lane_step;
  assign sq.lane_idx      = lane_q;
  assign sq.err           = err_q;

endmodule

// File: tb/tb_keccak_pi_sequencer.sv
// Scoreboard bench: each pass pushes its expected lane/done/error events,
// a negedge monitor pops and compares them as the sequencer produces them.
module tb_keccak_pi_sequencer;
  import keccak_pi_sequencer_pkg::*;

  localparam int TO      = 4;
  localparam int NOM_LAT = 1 + 2 * LANES + 1 + LANES + 1;
  localparam int BUDGET  = 2000;

  typedef struct {
    byte kind;
    int  val;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keccak_pi_sequencer_if sq();

  keccak_pi_sequencer #(.RD_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (sq)
  );

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  start_cyc = 0;
  int  rw_tab[LANES];
  int  ws_tab[LANES];
  bit  err_model = 1'b0;
  bit  mon_on    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input byte kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input byte kind, input int val);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got %c %0d, nothing expected (cycle %0d)", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        n_fail++;
        $display("FAIL event: got %c %0d, expected %c %0d (cycle %0d)",
                 kind, val, e.kind, e.val, cyc);
      end
    end
  endtask

  // Monitor: external lane-counter model plus event extraction.
  logic p_rst = 1'b1, p_busy = 1'b0, p_done = 1'b0, p_err = 1'b0;
  int   cnt_m = 0;
  int   run   = 0;

  always @(negedge clk) begin
    #1;
    if (mon_on) begin
      if (!p_rst) begin
        chk("reset_outputs", int'({sq.read_data, sq.cnt_init, sq.cnt_en, sq.ldn,
                                   sq.write_to_file, sq.busy, sq.done, sq.err}), 0);
        chk("reset_lane_idx", int'(sq.lane_idx), 0);
      end else begin
        chk("lane_idx_vs_counter", int'(sq.lane_idx), cnt_m);
      end
      if (!sq.busy)
        chk("idle_strobes", int'({sq.read_data, sq.ldn, sq.write_to_file,
                                  sq.done, sq.cnt_en, sq.cnt_init}), 0);
      if (sq.ldn) expect_ev("L", int'(sq.lane_idx));
      if (sq.write_to_file && sq.wr_ready && !sq.abort && rst)
        expect_ev("W", int'(sq.lane_idx));
      if (sq.done) expect_ev("D", cyc - start_cyc);
      if (!p_err && sq.err) expect_ev("E", run);
      if (p_err && !sq.err) expect_ev("C", cyc - start_cyc);
      if (p_busy && !sq.busy) expect_ev("B", int'({p_done, sq.err}));
    end
    if (!rst)             cnt_m = 0;
    else if (sq.cnt_init) cnt_m = 0;
    else if (sq.cnt_en)   cnt_m = cnt_m + 1;
    if (!sq.busy)           run = 0;
    else if (sq.read_data)  run = sq.rd_valid ? 0 : run + 1;
    p_rst  = rst;
    p_busy = sq.busy;
    p_done = sq.done;
    p_err  = sq.err;
  end

  task automatic fill_tabs(input int max_r, input int max_w);
    for (int i = 0; i < LANES; i++) begin
      rw_tab[i] = $urandom_range(max_r, 0);
      ws_tab[i] = $urandom_range(max_w, 0);
    end
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(negedge clk);
      sq.start    = 1'b0;
      sq.abort    = 1'($urandom);
      sq.rd_valid = 1'($urandom);
      sq.wr_ready = 1'($urandom);
    end
  endtask

  // Reference model: a pass is an ordered list of lane events whose total
  // length is the nominal latency plus every injected wait/stall cycle.
  // A negative lane argument disables that disturbance.
  task automatic run_pass(input int to_lane, input int ab_lane,
                          input int rs_lane, input int sp_lane);
    int  n_load, n_wr, lat, budget;
    int  r_ptr, r_left, w_ptr, w_left, l_cnt;
    bit  seen_busy, spur;
    if (err_model) push_ev("C", 1);
    err_model = 1'b0;
    n_load = (to_lane >= 0) ? to_lane : (rs_lane >= 0) ? rs_lane + 1 : LANES;
    for (int i = 0; i < n_load; i++) push_ev("L", i);
    if (to_lane < 0 && rs_lane < 0) begin
      n_wr = (ab_lane >= 0) ? ab_lane : LANES;
      for (int i = 0; i < n_wr; i++) push_ev("W", i);
    end
    if (to_lane >= 0) begin
      push_ev("E", TO);
      push_ev("B", 1);
      err_model = 1'b1;
    end else if (ab_lane >= 0 || rs_lane >= 0) begin
      push_ev("B", 0);
    end else begin
      lat = NOM_LAT;
      for (int i = 0; i < LANES; i++) lat += rw_tab[i] + ws_tab[i];
      push_ev("D", lat);
      push_ev("B", 2);
    end

    @(negedge clk);
    sq.start  = 1'b1;
    sq.abort  = 1'b0;
    start_cyc = cyc;
    r_ptr = 0; r_left = rw_tab[0];
    w_ptr = 0; w_left = ws_tab[0];
    l_cnt = 0; seen_busy = 1'b0; spur = 1'b0;
    budget = 0;
    while (budget < BUDGET) begin
      budget++;
      @(negedge clk);
      sq.start = 1'b0;
      sq.abort = 1'b0;
      if (sq.busy) seen_busy = 1'b1;
      else if (seen_busy) break;
      if (sq.ldn) begin
        if (l_cnt == rs_lane) begin
          rst = 1'b0;
          @(negedge clk);
          sq.start = 1'b1;
          @(negedge clk);
          sq.start = 1'b0;
          @(negedge clk);
          rst = 1'b1;
          err_model = 1'b0;
          break;
        end
        l_cnt++;
      end
      if (sq.read_data) begin
        if (r_ptr == sp_lane && !spur) begin
          sq.start = 1'b1;
          spur = 1'b1;
        end
        if (r_left > 0) begin
          sq.rd_valid = 1'b0;
          r_left--;
        end else begin
          sq.rd_valid = 1'b1;
          r_ptr++;
          r_left = (r_ptr < LANES) ? rw_tab[r_ptr] : 0;
        end
      end else begin
        sq.rd_valid = 1'($urandom);
      end
      if (sq.write_to_file) begin
        if (w_ptr == ab_lane) begin
          sq.abort    = 1'b1;
          sq.wr_ready = 1'b1;
        end else if (w_left > 0) begin
          sq.wr_ready = 1'b0;
          w_left--;
        end else begin
          sq.wr_ready = 1'b1;
          w_ptr++;
          w_left = (w_ptr < LANES) ? ws_tab[w_ptr] : 0;
        end
      end else begin
        sq.wr_ready = 1'($urandom);
      end
    end
    chk("pass_terminates", int'(budget < BUDGET), 1);
    idle_gap(3);
  endtask

  initial begin
    rst         = 1'b0;
    sq.start    = 1'b0;
    sq.abort    = 1'b0;
    sq.rd_valid = 1'b0;
    sq.wr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    mon_on = 1'b1;
    idle_gap(2);

    fill_tabs(0, 0);
    run_pass(-1, -1, -1, -1);

    fill_tabs(0, 0);
    ws_tab[7] = 3;
    run_pass(-1, -1, -1, -1);

    fill_tabs(0, 0);
    run_pass(-1, -1, -1, 5);

    fill_tabs(2, 2);
    rw_tab[3] = 1000;
    run_pass(3, -1, -1, -1);

    fill_tabs(3, 3);
    run_pass(-1, -1, -1, -1);

    fill_tabs(0, 0);
    run_pass(-1, 12, -1, -1);

    fill_tabs(3, 3);
    run_pass(-1, -1, -1, -1);

    fill_tabs(1, 1);
    run_pass(-1, -1, 10, -1);

    for (int p = 0; p < 3; p++) begin
      fill_tabs(3, 3);
      run_pass(-1, -1, -1, int'($urandom_range(LANES - 1, 0)));
    end

    idle_gap(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_pi_sequencer.md
Name: keccak_pi_sequencer

Overview:
Controller that sequences one full lane-permutation pass of the 5x5 x 64-bit state: read in 25 lanes, load each lane into the memory handler at its permuted address, then stream all 25 permuted lanes out to the file writer. It replaces the hand-timed readData / ldn / writeToFile pulses with a handshaked FSM. It drives the lane counter (init/enable), whose value feeds the existing index map -> converter -> index map chain.

Parameters:
LANES, 25, lanes per pass
IDX_W, 5, lane index width (ceil log2 LANES)
RD_TIMEOUT, 255, maximum cycles to wait for rd_valid per lane before error

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
start  in  1  begin a pass; sampled in IDLE only
abort  in  1  cancel the pass; return to IDLE
rd_valid  in  1  reader has presented the lane requested by read_data
wr_ready  in  1  file writer accepts the current lane this cycle
read_data  out  1  request the next lane from the reader
cnt_init  out  1  clear the lane counter
cnt_en  out  1  advance the lane counter
ldn  out  1  memory handler stores the lane at the converted address
write_to_file  out  1  output lane valid toward the file writer
lane_idx  out  IDX_W  current lane number (mirrors the counter)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on pass completion
err  out  1  sticky read-timeout flag; cleared by rst or the next accepted start

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; all outputs 0; lane_idx=0; timeout counter=0. Reset has priority over everything, including mid-pass; no done pulse is produced.
- IDLE: start=1 -> INIT; err cleared. While busy, start is ignored.
- INIT (1 cycle): cnt_init=1, lane_idx<=0 -> READ.
- READ: read_data=1. When rd_valid=1 -> LOAD, and the timeout counter clears. Each cycle without rd_valid, the timeout counter increments. When it reaches RD_TIMEOUT: err<=1 and state -> IDLE, with no done pulse.
- LOAD (1 cycle): ldn=1.
  - If lane_idx==LANES-1: -> WSETUP, with cnt_init=1 and lane_idx<=0.
  - Otherwise: cnt_en=1, lane_idx<=lane_idx+1 -> READ.
  - Minimum of 2 cycles per lane when rd_valid is already high.
- WSETUP (1 cycle): idle cycle that lets the counter and mapping settle -> WRITE.
- WRITE: write_to_file=1. When wr_ready=1, that lane is transferred.
  - If lane_idx==LANES-1: -> DONE.
  - Otherwise: cnt_en=1, lane_idx+1.
  - wr_ready low stalls; write_to_file stays high and lane_idx is held.
- DONE (1 cycle): done=1 -> IDLE.
- abort=1 in any non-IDLE state: -> IDLE next edge, all strobes 0, no done, err unchanged. Abort beats rd_valid and wr_ready in the same cycle.
- Strobes are Moore outputs decoded from the state register. The only exception is cnt_en/cnt_init, which are asserted in the same cycle as the lane_idx update, so lane_idx and the counter stay equal.
- lane_idx never exceeds LANES-1; no wrap within a pass.
- Minimum pass latency, start to done with rd_valid and wr_ready held high: 1 (INIT) + 25x2 + 1 (WSETUP) + 25 + 1 = 78 cycles after the start edge.

Decomposition:
- Shared package: state enum (IDLE, INIT, READ, LOAD, WSETUP, WRITE, DONE), LANES and IDX_W constants. The lane-map/converter modules also use these constants.
- One natural sub-module: rd_timeout_timer (load/clear/increment, expired flag).
- The FSM and lane_idx register stay in the top.

Test Plan:
- Nominal pass: rst low 2 cycles, start pulse, rd_valid and wr_ready tied 1 -> 25 ldn pulses with lane_idx 0..24, then 25 write_to_file cycles 0..24, done at cycle 78, busy falls with done.
- Backpressure: wr_ready low for 3 cycles at lane_idx=7 -> write_to_file held, lane_idx stays 7, done delayed by exactly 3 cycles.
- Read timeout: RD_TIMEOUT=4, rd_valid never asserted at lane 3 -> err=1 after 4 wait cycles, state IDLE, no done; next start clears err.
- Abort: abort during WRITE at lane_idx=12 -> all strobes 0 next cycle, busy=0, no done; a new start runs a full correct pass.
- Reset mid-pass: rst=0 during LOAD of lane 10 -> next edge all outputs 0, lane_idx=0; start ignored while rst=0.
- Start while busy: pulse start in READ lane 5 -> no effect; lane sequence and done timing unchanged.
